// File: rtl/panda_pkg.sv
// Shared types and constants for the panda core integer pipeline.
package panda_pkg;

    localparam int RegAddrW = $clog2(32);

    typedef enum logic {
        WB_SRC_EX,
        WB_SRC_LSU
    } wb_src_e;

endpackage

// File: rtl/panda_load_scoreboard.sv
// One busy bit per architectural register with an outstanding load; two
// combinational read ports for the decode hazard check.
module panda_load_scoreboard #(
    parameter  int Depth = 32,
    localparam int AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             set_i,
    input  logic [AddrW-1:0] set_addr_i,
    input  logic             clr_i,
    input  logic [AddrW-1:0] clr_addr_i,
    input  logic [AddrW-1:0] rs1_addr_i,
    input  logic [AddrW-1:0] rs2_addr_i,
    output logic             rs1_busy_o,
    output logic             rs2_busy_o
);

    logic [Depth-1:0] busy_q;
    logic [Depth-1:0] busy_d;

    // Set is applied after clear so a same-edge set/clear leaves the bit busy;
    // x0 can never hold a pending load.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy_o = busy_q[rs1_addr_i];
    assign rs2_busy_o = busy_q[rs2_addr_i];

endmodule

// File: rtl/panda_writeback_arbiter.sv
// Shares the register file write port between EX and LSU writeback, with an
// anti-starvation boost for LSU and a load scoreboard for decode stalls.
module panda_writeback_arbiter
    import panda_pkg::*;
#(
    parameter  int Width   = 32,
    parameter  int Depth   = 32,
    parameter  int MaxWait = 4,
    localparam int AddrW   = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ex_valid_i,
    output logic             ex_ready_o,
    input  logic [AddrW-1:0] ex_addr_i,
    input  logic [Width-1:0] ex_data_i,
    input  logic             lsu_valid_i,
    output logic             lsu_ready_o,
    input  logic [AddrW-1:0] lsu_addr_i,
    input  logic [Width-1:0] lsu_data_i,
    input  logic             issue_load_i,
    input  logic [AddrW-1:0] issue_addr_i,
    input  logic [AddrW-1:0] rs1_addr_i,
    input  logic [AddrW-1:0] rs2_addr_i,
    output logic             rs1_busy_o,
    output logic             rs2_busy_o,
    output logic [AddrW-1:0] rd_addr_o,
    output logic [Width-1:0] rd_data_o,
    output logic             rd_we_o
);

    localparam int CntW = 4;

    logic [CntW-1:0] wait_cnt_q;
    logic            starve_q;
    logic            ex_gnt;
    logic            lsu_gnt;
    wb_src_e         rd_src_q;
    logic            sb_clr;

    assign starve_q = (wait_cnt_q == CntW'(MaxWait));

    // EX normally wins; once LSU has waited MaxWait cycles it takes the port.
    assign lsu_gnt     = lsu_valid_i & (starve_q | ~ex_valid_i);
    assign ex_gnt      = ex_valid_i & ~lsu_gnt;
    assign ex_ready_o  = ex_gnt;
    assign lsu_ready_o = lsu_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else if (lsu_gnt) begin
            wait_cnt_q <= '0;
        end else if (lsu_valid_i && !starve_q) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // Writes to x0 still complete the handshake but never raise the enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_we_o   <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
            rd_src_q  <= WB_SRC_EX;
        end else begin
            rd_we_o <= 1'b0;
            if (ex_gnt) begin
                rd_we_o   <= (ex_addr_i != '0);
                rd_addr_o <= ex_addr_i;
                rd_data_o <= ex_data_i;
                rd_src_q  <= WB_SRC_EX;
            end else if (lsu_gnt) begin
                rd_we_o   <= (lsu_addr_i != '0);
                rd_addr_o <= lsu_addr_i;
                rd_data_o <= lsu_data_i;
                rd_src_q  <= WB_SRC_LSU;
            end
        end
    end

    // Busy clears only once the load data is actually being written.
    assign sb_clr = rd_we_o & (rd_src_q == WB_SRC_LSU);

    panda_load_scoreboard #(
        .Depth(Depth)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .set_i      (issue_load_i),
        .set_addr_i (issue_addr_i),
        .clr_i      (sb_clr),
        .clr_addr_i (rd_addr_o),
        .rs1_addr_i (rs1_addr_i),
        .rs2_addr_i (rs2_addr_i),
        .rs1_busy_o (rs1_busy_o),
        .rs2_busy_o (rs2_busy_o)
    );

endmodule

// File: tb/tb_panda_writeback_arbiter.sv
// Self-checking bench for panda_writeback_arbiter: expected register-file
// writes are queued as stimulus is applied and compared one cycle later.
module tb_panda_writeback_arbiter;
    import panda_pkg::*;

    localparam int W = 32;
    localparam int A = RegAddrW;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         ex_valid_i = 1'b0;
    logic         ex_ready_o;
    logic [A-1:0] ex_addr_i = '0;
    logic [W-1:0] ex_data_i = '0;
    logic         lsu_valid_i = 1'b0;
    logic         lsu_ready_o;
    logic [A-1:0] lsu_addr_i = '0;
    logic [W-1:0] lsu_data_i = '0;
    logic         issue_load_i = 1'b0;
    logic [A-1:0] issue_addr_i = '0;
    logic [A-1:0] rs1_addr_i = '0;
    logic [A-1:0] rs2_addr_i = '0;
    logic         rs1_busy_o;
    logic         rs2_busy_o;
    logic [A-1:0] rd_addr_o;
    logic [W-1:0] rd_data_o;
    logic         rd_we_o;

    typedef struct {
        logic         we;
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [A-1:0] model_addr = '0;
    logic [W-1:0] model_data = '0;
    int           n_compared = 0;
    int           n_mismatched = 0;

    panda_writeback_arbiter #(
        .Width(32),
        .Depth(32),
        .MaxWait(4)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ex_valid_i   (ex_valid_i),
        .ex_ready_o   (ex_ready_o),
        .ex_addr_i    (ex_addr_i),
        .ex_data_i    (ex_data_i),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_data_i   (lsu_data_i),
        .issue_load_i (issue_load_i),
        .issue_addr_i (issue_addr_i),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rs1_busy_o   (rs1_busy_o),
        .rs2_busy_o   (rs2_busy_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .rd_we_o      (rd_we_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, checks readies, queues the expected write,
    // then compares the registered output one cycle later.
    task automatic applyStimulus(input string tag,
                                 input logic ev, input logic [A-1:0] ea, input logic [W-1:0] ed,
                                 input logic lv, input logic [A-1:0] la, input logic [W-1:0] ld,
                                 input logic iv, input logic [A-1:0] ia,
                                 input logic exp_er, input logic exp_lr);
        exp_t e;
        ex_valid_i   = ev;
        ex_addr_i    = ea;
        ex_data_i    = ed;
        lsu_valid_i  = lv;
        lsu_addr_i   = la;
        lsu_data_i   = ld;
        issue_load_i = iv;
        issue_addr_i = ia;
        #1;
        checkOutput({tag, ".ex_ready"}, 64'(ex_ready_o), 64'(exp_er));
        checkOutput({tag, ".lsu_ready"}, 64'(lsu_ready_o), 64'(exp_lr));
        e.we = 1'b0;
        if (exp_er && ev) begin
            model_addr = ea;
            model_data = ed;
            e.we       = (ea != 0);
        end else if (exp_lr && lv) begin
            model_addr = la;
            model_data = ld;
            e.we       = (la != 0);
        end
        e.addr = model_addr;
        e.data = model_data;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        ex_valid_i   = 1'b0;
        lsu_valid_i  = 1'b0;
        issue_load_i = 1'b0;
        if (exp_q.size() == 0) begin
            checkOutput({tag, ".queue_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            checkOutput({tag, ".rd_we"}, 64'(rd_we_o), 64'(e.we));
            checkOutput({tag, ".rd_addr"}, 64'(rd_addr_o), 64'(e.addr));
            checkOutput({tag, ".rd_data"}, 64'(rd_data_o), 64'(e.data));
        end
    endtask

    task automatic checkBusy(input string tag, input logic [A-1:0] r1, input logic exp1,
                             input logic [A-1:0] r2, input logic exp2);
        rs1_addr_i = r1;
        rs2_addr_i = r2;
        #1;
        checkOutput({tag, ".rs1_busy"}, 64'(rs1_busy_o), 64'(exp1));
        checkOutput({tag, ".rs2_busy"}, 64'(rs2_busy_o), 64'(exp2));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset.rd_we", 64'(rd_we_o), 64'd0);
        checkOutput("reset.rd_addr", 64'(rd_addr_o), 64'd0);
        checkOutput("reset.rd_data", 64'(rd_data_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        checkBusy("reset", 5'd9, 1'b0, 5'd4, 1'b0);

        applyStimulus("ex_only", 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 5'd0, 1, 0);
        applyStimulus("idle", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("cont%0d", i), 1, 5'd3, 32'h3000 + 32'(i),
                          1, 5'd7, 32'h7777, 0, 5'd0, 1, 0);
        end
        applyStimulus("cont_starve", 1, 5'd3, 32'h3004, 1, 5'd7, 32'h7777, 0, 5'd0, 0, 1);
        applyStimulus("cont_after", 1, 5'd3, 32'h3004, 1, 5'd7, 32'h7778, 0, 5'd0, 1, 0);
        applyStimulus("lsu_only", 0, 5'd0, 32'h0, 1, 5'd7, 32'h7778, 0, 5'd0, 0, 1);

        applyStimulus("issue9", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 0, 0);
        checkBusy("issue9", 5'd9, 1'b1, 5'd7, 1'b0);
        applyStimulus("ld9", 0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 0, 5'd0, 0, 1);
        checkBusy("ld9_we", 5'd9, 1'b1, 5'd0, 1'b0);
        applyStimulus("ld9_post", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0);
        checkBusy("ld9_clr", 5'd9, 1'b0, 5'd0, 1'b0);

        applyStimulus("issue12", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd12, 0, 0);
        applyStimulus("ex12", 1, 5'd12, 32'h1212, 0, 5'd0, 32'h0, 0, 5'd0, 1, 0);
        applyStimulus("ex12_post", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0);
        checkBusy("ex12", 5'd12, 1'b1, 5'd9, 1'b0);
        applyStimulus("ld12", 0, 5'd0, 32'h0, 1, 5'd12, 32'hC0C0, 0, 5'd0, 0, 1);
        applyStimulus("ld12_post", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0);
        checkBusy("ld12", 5'd12, 1'b0, 5'd9, 1'b0);

        applyStimulus("sc_issue", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 0, 0);
        applyStimulus("sc_ld", 0, 5'd0, 32'h0, 1, 5'd9, 32'hAAAA, 0, 5'd0, 0, 1);
        applyStimulus("sc_reissue", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 0, 0);
        checkBusy("same_edge", 5'd9, 1'b1, 5'd12, 1'b0);
        applyStimulus("sc_ld2", 0, 5'd0, 32'h0, 1, 5'd9, 32'hBBBB, 0, 5'd0, 0, 1);
        applyStimulus("sc_post", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0);
        checkBusy("sc_clr", 5'd9, 1'b0, 5'd12, 1'b0);

        applyStimulus("x0", 1, 5'd0, 32'h123, 0, 5'd0, 32'h0, 1, 5'd0, 1, 0);
        checkBusy("x0", 5'd0, 1'b0, 5'd9, 1'b0);
        applyStimulus("x0_lsu", 0, 5'd0, 32'h0, 1, 5'd0, 32'h456, 0, 5'd0, 0, 1);

        applyStimulus("rst_issue", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd4, 0, 0);
        applyStimulus("rst_ex", 1, 5'd4, 32'h4444, 0, 5'd0, 32'h0, 0, 5'd0, 1, 0);
        checkBusy("rst_pre", 5'd4, 1'b1, 5'd0, 1'b0);
        #1;
        rst_ni = 1'b0;
        #1;
        checkOutput("rst_mid.rd_we", 64'(rd_we_o), 64'd0);
        checkOutput("rst_mid.rd_addr", 64'(rd_addr_o), 64'd0);
        checkOutput("rst_mid.rd_data", 64'(rd_data_o), 64'd0);
        checkBusy("rst_mid", 5'd4, 1'b0, 5'd12, 1'b0);
        model_addr = '0;
        model_data = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus("rst_after", 1, 5'd6, 32'h6666, 0, 5'd0, 32'h0, 0, 5'd0, 1, 0);
        applyStimulus("rst_idle", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/panda_writeback_arbiter.md
Name: panda_writeback_arbiter

Overview:
- Owns the single write port (rd) of the integer register file and shares it between two writeback sources: the execute stage (EX) and the load/store unit (LSU, returning load data).
- Also holds a load scoreboard: one busy bit per register with an outstanding load, so decode can stall readers until the load data has actually been written.
- Sits between EX/LSU and the register file. Its rs1/rs2 busy outputs feed the decode-stage hazard logic.

Parameters:
- Width, 32, register data width
- Depth, 32, number of architectural registers (power of two); AddrW = $clog2(Depth)
- MaxWait, 4, consecutive stalled LSU cycles after which LSU takes priority over EX (range 1..15)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- ex_valid_i  in  1  EX has a result to write
- ex_ready_o  out  1  EX result accepted this cycle
- ex_addr_i  in  AddrW  EX destination register
- ex_data_i  in  Width  EX result
- lsu_valid_i  in  1  LSU has load data to write
- lsu_ready_o  out  1  LSU data accepted this cycle
- lsu_addr_i  in  AddrW  load destination register
- lsu_data_i  in  Width  load data
- issue_load_i  in  1  decode issues a load this cycle
- issue_addr_i  in  AddrW  destination of the issued load
- rs1_addr_i  in  AddrW  decode source 1 address
- rs2_addr_i  in  AddrW  decode source 2 address
- rs1_busy_o  out  1  rs1 has a pending load
- rs2_busy_o  out  1  rs2 has a pending load
- rd_addr_o  out  AddrW  register file write address
- rd_data_o  out  Width  register file write data
- rd_we_o  out  1  register file write enable

Behaviour:
- Reset values: rd_addr_o=0, rd_data_o=0, rd_we_o=0, all busy bits=0, starvation counter=0, priority=EX.
- Handshake (valid/ready): a transfer happens when valid&ready. Requesters hold addr/data stable while valid&~ready, and valid never depends on ready. ready is combinational from the valids and the priority state.
- At most one grant per cycle.
  - Default priority: EX over LSU.
  - When starve_q is set, LSU wins over EX.
- Starvation counter: increments each cycle lsu_valid_i&~lsu_ready_o, saturating at MaxWait. Clears on an LSU grant. starve_q = (count==MaxWait).
- Output stage is registered, latency 1. A grant in cycle N drives rd_addr_o/rd_data_o/rd_we_o in cycle N+1, and the register file captures at the end of N+1. With no grant in N, rd_we_o=0 in N+1 and addr/data hold.
- x0 writes: the grant and handshake complete normally, but rd_we_o stays 0.
- Scoreboard:
  - Setting: issue_load_i with issue_addr_i!=0 sets busy[issue_addr_i] at the next edge. An issue to x0 is ignored.
  - Clearing: a busy bit clears at the edge ending the cycle in which rd_we_o=1 with source LSU (a registered source flag). It does not clear at grant time, so a reader never sees busy=0 before the data is in the file.
  - A same-edge set and clear of the same register leaves it busy (set wins).
- rsN_busy_o = busy[rsN_addr_i], purely combinational from the registered bits. busy[0] is always 0.
- An EX write to a busy register is allowed and does not clear its busy bit.
- An LSU writeback to a non-busy register is legal. No error is raised.
- Asserting reset mid-operation drops any registered write (rd_we_o=0 immediately, asynchronously) and clears all busy bits and the counter.

Decomposition:
- panda_pkg additions: localparam RegAddrW = $clog2(32); typedef wb_src_e {WB_SRC_EX, WB_SRC_LSU}.
- One sub-module, panda_load_scoreboard (Depth busy bits, set/clear ports, two read ports). The arbiter, starvation counter and output register stay in the top.

Test Plan:
- EX only: ex_valid=1, addr=5, data=0xDEADBEEF in cycle N -> ex_ready=1 in N; in N+1 rd_we=1, rd_addr=5, rd_data=0xDEADBEEF.
- Contention: both valid every cycle, EX addr 3, LSU addr 7, MaxWait=4 -> EX granted 4 cycles, LSU granted in the 5th, counter back to 0, then EX again.
- Scoreboard: issue_load addr=9 at N -> rs1_busy=1 (rs1_addr=9) from N+1. LSU grant for 9 at M -> rd_we=1 at M+1, busy still 1 during M+1, 0 from M+2.
- Set and clear same edge: LSU writeback of reg 9 in rd_we cycle while issue_load addr=9 -> busy[9] remains 1.
- x0: EX writes addr 0, and issue_load addr 0 -> handshake completes, rd_we stays 0, rs1_busy (addr 0) stays 0.
- Reset mid-stream: rst_ni low while rd_we=1 and busy[4]=1 -> rd_we=0 immediately, all busy 0; after release, first grant appears with 1-cycle latency.
